// File: rtl/mems_pkg.sv
// rtl/mems_pkg.sv - shared constants and FSM state type for the activation-memory read streamer
package mems_pkg;
  localparam int DW         = 64;
  localparam int AW         = 16;
  localparam int ROW_AW     = 14;
  localparam int BANK_BITS  = 2;
  localparam int LW         = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with registered storage and exposed occupancy
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             pop;

  assign valid   = (count != '0);
  assign rd_data = mem[rptr];
  assign pop     = rd_en && valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mems_rd_stream.sv
// rtl/mems_rd_stream.sv - issues banked single-word reads and streams them out through a credit-limited FIFO
module mems_rd_stream import mems_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_AW-1:0] base_row,
  input  logic [LW-1:0]     len,
  output logic              busy,
  output logic              done,
  input  logic              mem_wr_active,
  output logic              mem_ren,
  output logic [AW-1:0]     mem_rd_ptr,
  input  logic [DW-1:0]     mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_last
);
  state_t            state;
  logic [ROW_AW-1:0] base_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     k;
  logic [LW-1:0]     k1;
  logic              pend;
  logic              pend_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  credit_use;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic [DW:0]       fifo_rd;

  // A read in flight still needs a FIFO slot next cycle, so it counts against the credit.
  assign k1         = k + 1'b1;
  assign credit_use = fifo_count + CNT_W'(pend);
  assign issue      = (state == RUN) && !mem_wr_active && (k < len_q) &&
                      (credit_use < CNT_W'(FIFO_DEPTH));
  assign last_issue = issue && (k1 == len_q);
  assign mem_ren    = issue;
  assign pop        = m_valid && m_ready;
  assign m_data     = fifo_rd[DW-1:0];
  assign m_last     = fifo_rd[DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_ptr <= '0;
      base_q     <= '0;
      len_q      <= '0;
      k          <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      done      <= 1'b0;
      pend      <= issue;
      pend_last <= last_issue;
      // The pointer always holds the address of the next word to be read.
      if (issue) begin
        k          <= k1;
        mem_rd_ptr <= {k1[BANK_BITS-1:0], base_q + k1[LW-1:BANK_BITS]};
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              base_q     <= base_row;
              len_q      <= len;
              k          <= '0;
              mem_rd_ptr <= {BANK_BITS'(0), base_row};
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (pend),
    .wr_data({pend_last, mem_dout}),
    .rd_en  (pop),
    .rd_data(fifo_rd),
    .valid  (m_valid),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_mems_rd_stream.sv
// tb/tb_mems_rd_stream.sv - directed self-checking bench for mems_rd_stream
module tb_mems_rd_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_row = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        mem_wr_active = 1'b0;
  logic        mem_ren;
  logic [15:0] mem_rd_ptr;
  logic [63:0] mem_dout = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        m_last;

  int tests = 0;
  int fails = 0;

  logic [15:0] ptr_q[$];
  int          ren_cyc_q[$];
  logic [63:0] data_q[$];
  logic        last_q[$];
  int          beat_cyc_q[$];
  int          done_cyc, busy_hi, ren_err, ren_wr, hold_err;
  logic        busy_at_done;
  logic        timeout;

  mems_rd_stream dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_row     (base_row),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .mem_wr_active(mem_wr_active),
    .mem_ren      (mem_ren),
    .mem_rd_ptr   (mem_rd_ptr),
    .mem_dout     (mem_dout),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [15:0] p);
    return {p, ~p, p ^ 16'h5AA5, 16'hC0DE};
  endfunction

  function automatic logic [15:0] exp_ptr(input logic [13:0] b, input int k);
    logic [15:0] kk;
    logic [13:0] row;
    kk  = 16'(k);
    row = b + kk[15:2];
    return {kk[1:0], row};
  endfunction

  // One-cycle-latency memory model
  always @(posedge clk) begin
    if (mem_ren === 1'b1) mem_dout <= pat(mem_rd_ptr);
  end

  task automatic run_burst(input logic [13:0] b, input logic [15:0] n, input int rmode,
                           input int wr_from, input int wr_cnt, input int stop_beats,
                           input int restart_cyc);
    int          issued;
    int          popped;
    int          diff;
    logic        exp_ren;
    logic        pv;
    logic        pr;
    logic [64:0] prev;
    ptr_q.delete(); ren_cyc_q.delete(); data_q.delete(); last_q.delete(); beat_cyc_q.delete();
    done_cyc = -1; busy_hi = 0; ren_err = 0; ren_wr = 0; hold_err = 0;
    busy_at_done = 1'b1; timeout = 1'b0;
    issued = 0; popped = 0; pv = 1'b0; pr = 1'b1; prev = '0;
    @(posedge clk); #1;
    start = 1'b1; base_row = b; len = n; m_ready = 1'b1; mem_wr_active = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      m_ready       = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_wr_active = (cyc >= wr_from) && (cyc < wr_from + wr_cnt);
      start         = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        base_row = b ^ 14'h3FFF;
        len      = 16'd3;
      end
      #1;
      diff    = issued - popped;
      exp_ren = (issued < int'(n)) && (diff < 4) && !mem_wr_active;
      if (mem_ren !== exp_ren) ren_err++;
      if (mem_ren === 1'b1 && mem_wr_active) ren_wr++;
      if (mem_ren === 1'b1) begin
        ptr_q.push_back(mem_rd_ptr);
        ren_cyc_q.push_back(cyc);
        issued++;
      end
      if (pv && !pr && (m_valid !== 1'b1 || {m_last, m_data} !== prev)) hold_err++;
      if (m_valid === 1'b1 && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        beat_cyc_q.push_back(cyc);
        popped++;
      end
      pv = (m_valid === 1'b1); pr = m_ready; prev = {m_last, m_data};
      if (busy === 1'b1 && done_cyc < 0) busy_hi++;
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (stop_beats > 0 && popped == stop_beats) break;
      if (done_cyc >= 0) break;
      if (cyc == 300) timeout = 1'b1;
    end
    start = 1'b0; mem_wr_active = 1'b0; m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if ({busy, done, mem_ren, m_valid, m_last} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: busy/done/ren/valid/last=%b want 00000",
               {busy, done, mem_ren, m_valid, m_last});
    end
    tests++;
    if (mem_rd_ptr !== 16'h0) begin
      fails++; $display("FAIL reset_ptr: got %h want 0000", mem_rd_ptr);
    end
    tests++;
    if (m_data !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", m_data);
    end
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] tbl [8];
    tbl = '{16'h0010, 16'h4010, 16'h8010, 16'hC010, 16'h0011, 16'h4011, 16'h8011, 16'hC011};
    run_burst(14'h0010, 16'd8, 0, 0, 0, 0, 0);
    tests++;
    if (timeout !== 1'b0 || ptr_q.size() != 8 || data_q.size() != 8) begin
      fails++;
      $display("FAIL basic_counts: reads=%0d beats=%0d timeout=%b want 8 8 0",
               ptr_q.size(), data_q.size(), timeout);
    end
    for (int i = 0; i < 8 && i < ptr_q.size(); i++) begin
      tests++;
      if (ptr_q[i] !== tbl[i] || ren_cyc_q[i] != i + 1) begin
        fails++;
        $display("FAIL basic_ptr[%0d]: got %h at cycle %0d want %h at cycle %0d",
                 i, ptr_q[i], ren_cyc_q[i], tbl[i], i + 1);
      end
    end
    for (int i = 0; i < 8 && i < data_q.size(); i++) begin
      tests++;
      if (data_q[i] !== pat(tbl[i]) || last_q[i] !== (i == 7) || beat_cyc_q[i] != i + 3) begin
        fails++;
        $display("FAIL basic_beat[%0d]: data %h last %b cycle %0d want %h %b %0d",
                 i, data_q[i], last_q[i], beat_cyc_q[i], pat(tbl[i]), (i == 7), i + 3);
      end
    end
    tests++;
    if (done_cyc != 11 || busy_hi != 10 || busy_at_done !== 1'b0 || ren_err != 0) begin
      fails++;
      $display("FAIL basic_timing: done@%0d busy_cycles=%0d busy_at_done=%b ren_err=%0d want 11 10 0 0",
               done_cyc, busy_hi, busy_at_done, ren_err);
    end
  endtask

  task automatic test_backpressure();
    int errs;
    run_burst(14'h0123, 16'd20, 1, 0, 0, 0, 0);
    tests++;
    if (timeout !== 1'b0 || data_q.size() != 20 || ptr_q.size() != 20 || done_cyc < 0) begin
      fails++;
      $display("FAIL bp_counts: beats=%0d reads=%0d done@%0d timeout=%b want 20 20 done 0",
               data_q.size(), ptr_q.size(), done_cyc, timeout);
    end
    errs = 0;
    for (int i = 0; i < data_q.size(); i++)
      if (data_q[i] !== pat(exp_ptr(14'h0123, i)) || last_q[i] !== (i == 19)) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL bp_order: %0d bad beats want 0", errs);
    end
    tests++;
    if (ren_err != 0 || hold_err != 0) begin
      fails++;
      $display("FAIL bp_credit_hold: ren_err=%0d hold_err=%0d want 0 0", ren_err, hold_err);
    end
  endtask

  task automatic test_zero_len();
    run_burst(14'h0050, 16'd0, 0, 0, 0, 0, 0);
    tests++;
    if (done_cyc != 1 || ptr_q.size() != 0 || busy_hi != 0 || busy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL zero_len: done@%0d reads=%0d busy_cycles=%0d want 1 0 0",
               done_cyc, ptr_q.size(), busy_hi);
    end
    @(posedge clk); #2;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_ren !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_after: done=%b busy=%b ren=%b want 0 0 0", done, busy, mem_ren);
    end
  endtask

  task automatic test_row_wrap();
    logic [15:0] tbl [6];
    int errs;
    tbl = '{16'h3FFF, 16'h7FFF, 16'hBFFF, 16'hFFFF, 16'h0000, 16'h4000};
    run_burst(14'h3FFF, 16'd6, 0, 0, 0, 0, 0);
    tests++;
    if (ptr_q.size() != 6 || data_q.size() != 6 || done_cyc != 9) begin
      fails++;
      $display("FAIL wrap_counts: reads=%0d beats=%0d done@%0d want 6 6 9",
               ptr_q.size(), data_q.size(), done_cyc);
    end
    errs = 0;
    for (int i = 0; i < 6 && i < ptr_q.size() && i < data_q.size(); i++)
      if (ptr_q[i] !== tbl[i] || data_q[i] !== pat(tbl[i])) errs++;
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL wrap_ptrs: %0d bad pointer/data entries want 0", errs);
    end
  endtask

  task automatic test_write_collision();
    int errs;
    run_burst(14'h0200, 16'd12, 0, 4, 3, 0, 0);
    tests++;
    if (ren_wr != 0 || ren_err != 0) begin
      fails++;
      $display("FAIL wr_stall: ren_during_write=%0d ren_err=%0d want 0 0", ren_wr, ren_err);
    end
    tests++;
    if (ren_cyc_q.size() != 12 || ren_cyc_q[3] != 7 || done_cyc != 18) begin
      fails++;
      $display("FAIL wr_timing: reads=%0d 4th read@%0d done@%0d want 12 7 18",
               ren_cyc_q.size(), (ren_cyc_q.size() > 3) ? ren_cyc_q[3] : -1, done_cyc);
    end
    errs = 0;
    for (int i = 0; i < data_q.size(); i++)
      if (data_q[i] !== pat(exp_ptr(14'h0200, i)) || last_q[i] !== (i == 11)) errs++;
    tests++;
    if (errs != 0 || data_q.size() != 12) begin
      fails++;
      $display("FAIL wr_order: beats=%0d bad=%0d want 12 0", data_q.size(), errs);
    end
  endtask

  task automatic test_reset_mid();
    int errs;
    run_burst(14'h0100, 16'd16, 0, 0, 0, 3, 0);
    tests++;
    if (data_q.size() != 3) begin
      fails++; $display("FAIL rstmid_pre: beats=%0d want 3", data_q.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, mem_ren, m_valid, m_last} !== 5'b0 || mem_rd_ptr !== 16'h0 || m_data !== 64'h0) begin
      fails++;
      $display("FAIL rstmid_outputs: flags=%b ptr=%h data=%h want 00000 0000 0",
               {busy, done, mem_ren, m_valid, m_last}, mem_rd_ptr, m_data);
    end
    @(posedge clk); #2;
    tests++;
    if (m_valid !== 1'b0 || mem_ren !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_discard: valid=%b ren=%b want 0 0", m_valid, mem_ren);
    end
    run_burst(14'h0200, 16'd4, 0, 0, 0, 0, 2);
    errs = 0;
    for (int i = 0; i < 4 && i < ptr_q.size() && i < data_q.size(); i++)
      if (ptr_q[i] !== exp_ptr(14'h0200, i) || data_q[i] !== pat(exp_ptr(14'h0200, i)) ||
          last_q[i] !== (i == 3)) errs++;
    tests++;
    if (errs != 0 || ptr_q.size() != 4 || data_q.size() != 4 || done_cyc != 7 || ren_err != 0) begin
      fails++;
      $display("FAIL rstmid_restart: reads=%0d beats=%0d bad=%0d done@%0d ren_err=%0d want 4 4 0 7 0",
               ptr_q.size(), data_q.size(), errs, done_cyc, ren_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_row_wrap();
    test_write_collision();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
